// File: rtl/frame_buffer_pkg.sv
// Shared state encoding and slot arithmetic for the frame buffer ring scheduler.
package frame_buffer_pkg;

   localparam int HA_BITS_DEF = 8;

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_RUN      = 2'd1,
      ST_DRAIN    = 2'd2
   } fbs_state_e;

   function automatic logic [HA_BITS_DEF-1:0] slot_step(input logic [2:0] bs);
      return HA_BITS_DEF'(1) << bs;
   endfunction

   function automatic logic [HA_BITS_DEF:0] slot_count(input logic [2:0] bs);
      return (HA_BITS_DEF+1)'(1) << (HA_BITS_DEF - int'(bs));
   endfunction

endpackage

// File: rtl/frame_slot_grant.sv
// One slot-grant channel: registered tvalid/tdata offer plus the outstanding-slot flag.
module frame_slot_grant #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear_i,
   input  logic         offer_i,
   input  logic [W-1:0] addr_i,
   input  logic         tready_i,
   input  logic         done_i,
   output logic         tvalid_o,
   output logic [W-1:0] tdata_o,
   output logic         out_nxt_o,
   output logic         done_ok_o,
   output logic         err_o
);

   logic         tvalid_q, tvalid_d;
   logic         out_q, out_d;
   logic [W-1:0] tdata_q;
   logic         hs;

   assign hs        = tvalid_q & tready_i;
   assign done_ok_o = done_i & out_q;
   assign err_o     = done_i & ~out_q;

   assign out_d = clear_i   ? 1'b0 :
                  hs        ? 1'b1 :
                  done_ok_o ? 1'b0 : out_q;

   // offer_i is built from next-cycle state, so a re-offer lands the cycle after done.
   assign tvalid_d = offer_i & ~out_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
         out_q    <= 1'b0;
      end else begin
         tvalid_q <= tvalid_d;
         tdata_q  <= addr_i;
         out_q    <= out_d;
      end
   end

   assign tvalid_o  = tvalid_q;
   assign tdata_o   = tdata_q;
   assign out_nxt_o = out_d;

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Hands frame buffer ring slots to one writer and one reader in order; owns pointers and fill.
module frame_buffer_scheduler
   import frame_buffer_pkg::*;
#(
   parameter int HA_BITS  = HA_BITS_DEF,
   parameter int CNT_BITS = 9
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic                enable,
   input  logic [2:0]          buffer_size,
   output logic [HA_BITS-1:0]  m_wr_tdata,
   output logic                m_wr_tvalid,
   input  logic                m_wr_tready,
   input  logic                wr_done,
   output logic [HA_BITS-1:0]  m_rd_tdata,
   output logic                m_rd_tvalid,
   input  logic                m_rd_tready,
   input  logic                rd_done,
   output logic [CNT_BITS-1:0] filled_count,
   output logic                busy,
   output logic                err
);

   fbs_state_e          state_q, state_d;
   logic [2:0]          bs_q, bs_d;
   logic [HA_BITS-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, step;
   logic [CNT_BITS-1:0] fill_q, fill_d, n_d;
   logic [CNT_BITS:0]   wr_need;
   logic                err_q, err_d;
   logic                clear, run_nxt, rd_hs, wr_offer, rd_offer;
   logic                wr_out_nxt, wr_done_ok, wr_err;
   logic                rd_out_nxt, rd_done_ok, rd_err;

   always_comb begin
      state_d = state_q;
      bs_d    = bs_q;
      case (state_q)
         ST_DISABLED: if (enable) begin
            state_d = ST_RUN;
            bs_d    = buffer_size;
         end
         ST_RUN:      if (!enable) state_d = ST_DRAIN;
         ST_DRAIN:    if (!wr_out_nxt && !rd_out_nxt) state_d = ST_DISABLED;
         default:     state_d = ST_DISABLED;
      endcase
   end

   assign clear   = (state_q == ST_DISABLED) && enable;
   assign run_nxt = (state_d == ST_RUN);
   assign step    = HA_BITS'(slot_step(bs_q));
   assign n_d     = CNT_BITS'(slot_count(bs_d));
   assign rd_hs   = m_rd_tvalid & m_rd_tready;

   assign wr_ptr_d = clear ? '0 : wr_done_ok ? wr_ptr_q + step : wr_ptr_q;
   assign rd_ptr_d = clear ? '0 : rd_done_ok ? rd_ptr_q + step : rd_ptr_q;
   assign fill_d   = clear ? '0 : fill_q + CNT_BITS'(wr_done_ok) - CNT_BITS'(rd_hs);
   assign err_d    = err_q | wr_err | rd_err;

   // The writer's own flag is already excluded inside the grant channel; a read in
   // flight still pins its slot.
   assign wr_need  = {1'b0, fill_d} + (CNT_BITS+1)'(rd_out_nxt);
   assign wr_offer = run_nxt && (wr_need < {1'b0, n_d});
   assign rd_offer = run_nxt && (fill_d != '0);

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q  <= ST_DISABLED;
         bs_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         bs_q     <= bs_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         err_q    <= err_d;
      end
   end

   frame_slot_grant #(.W(HA_BITS)) u_wr (
      .clk       (aclk),
      .rst_n     (aresetn),
      .clear_i   (clear),
      .offer_i   (wr_offer),
      .addr_i    (wr_ptr_d),
      .tready_i  (m_wr_tready),
      .done_i    (wr_done),
      .tvalid_o  (m_wr_tvalid),
      .tdata_o   (m_wr_tdata),
      .out_nxt_o (wr_out_nxt),
      .done_ok_o (wr_done_ok),
      .err_o     (wr_err)
   );

   frame_slot_grant #(.W(HA_BITS)) u_rd (
      .clk       (aclk),
      .rst_n     (aresetn),
      .clear_i   (clear),
      .offer_i   (rd_offer),
      .addr_i    (rd_ptr_d),
      .tready_i  (m_rd_tready),
      .done_i    (rd_done),
      .tvalid_o  (m_rd_tvalid),
      .tdata_o   (m_rd_tdata),
      .out_nxt_o (rd_out_nxt),
      .done_ok_o (rd_done_ok),
      .err_o     (rd_err)
   );

   assign filled_count = fill_q;
   assign busy         = (state_q != ST_DISABLED);
   assign err          = err_q;

endmodule
